nf_debug_vector_reader: RTL and testbench
=========================================

NF_DEBUG_VECTOR_READER -- requirements
Module: nf_debug_vector_reader

Interface
REQ-001 SHALL have port axi_aclk, input, 1, the single clock; every flop in the block is in this domain.
REQ-002 SHALL have port axi_resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port debug_vector, input, 384, the packed platform status of 4 ports x 96 bits, quasi-static. Port1 is [383:288], port2 [287:192], port3 [191:96], port4 [95:0].
REQ-004 SHALL have port snap_req, input, 1, a single-cycle pulse requesting a snapshot.
REQ-005 SHALL have port rd_req, input, 1, a read request held by the requester until rd_ack.
REQ-006 SHALL have port rd_addr, input, 4, the word index, stable while rd_req is high.
REQ-007 SHALL have port rd_ack, output, 1, a one-cycle read completion pulse.
REQ-008 SHALL have port rd_data, output, 32, the read data, valid only while rd_ack is high and 0 otherwise.
REQ-009 SHALL have port rd_err, output, 1, asserted together with rd_ack when the address is invalid.
REQ-010 SHALL have port snap_count, output, 16, the number of snapshots taken, wrapping.
REQ-011 SHALL have port change_flags, output, 4, sticky per-port change flags (bit0 = port1).
REQ-012 SHALL have port clear_change, input, 1, a single-cycle pulse clearing change_flags.

Function
REQ-013 SHALL register debug_vector through two flop stages (s1, s2) before any other use.
REQ-014 SHALL implement an FSM with states IDLE, CAPTURE and RESP.
REQ-015 In IDLE, SHALL go to CAPTURE when snap_req=1 and otherwise to RESP when rd_req=1. Snapshot has priority; a pending rd_req stays pending.
REQ-016 In CAPTURE, SHALL load the 384-bit snapshot register from s2, increment snap_count (0xFFFF wraps to 0x0000), and return to IDLE.
REQ-017 SHALL ignore a snap_req pulse that arrives in CAPTURE or RESP; it is not queued.
REQ-018 On entering RESP, SHALL register rd_data/rd_err; in RESP, SHALL drive rd_ack=1 for exactly one cycle, then return to IDLE. Read latency is the accept edge plus one cycle.
REQ-019 SHALL sample rd_req only in IDLE. The requester drops rd_req in the cycle after rd_ack, so each request produces exactly one rd_ack.
REQ-020 For addr k in 0..11, SHALL return rd_data = snapshot[383-32k : 352-32k], with rd_err=0.
REQ-021 For addr 12, SHALL return rd_data = {snap_count, 12'b0, change_flags}, with rd_err=0. These are the live values at the accept edge.
REQ-022 For addr 13..15, SHALL return rd_data=0 and rd_err=1.
REQ-023 Before the first snapshot, SHALL hold the snapshot register at all-zero, so words 0..11 read 0.
REQ-024 SHALL never change the snapshot register except in CAPTURE, so reads are coherent across the 12 words.

Reset
REQ-025 With axi_resetn=0, SHALL immediately clear s1, s2, the snapshot, snap_count, change_flags, rd_ack, rd_data and rd_err, and set the FSM to IDLE.
REQ-026 SHALL abort any in-flight read on reset mid-operation without emitting rd_ack. The requester re-issues the read after release.
REQ-027 SHALL accept requests starting from the first rising edge after axi_resetn deasserts.

Configuration
REQ-028 Macro NF_DEBUG_VECTOR_CHANGE_DETECT_EN enables change detection; the behaviour SHALL be as follows.
REQ-029 With the macro defined: an extra stage s3 follows s2. change_flags[i] sets when port-i slices of s2 and s3 differ. clear_change zeroes all flags. On the same-cycle set and clear of a bit, set wins.
REQ-030 With the macro undefined: s3 and the compare logic are absent, change_flags is tied to 0, and clear_change is ignored.

Verification
REQ-031 Reset: assert axi_resetn=0 mid-read -> rd_ack never pulses; all outputs are 0; after release, a read of addr 12 returns 0x00000000.
REQ-032 Readout: set word k of debug_vector = 0xA5000000+k, pulse snap_req, wait 4 cycles, read addr 5 -> rd_ack one cycle after accept, rd_data=0xA5000005, rd_err=0; snap_count=1.
REQ-033 Coherence: after snapshot, change debug_vector to all-ones, then read addr 0 -> 0xA5000000.
REQ-034 Priority: snap_req and rd_req(addr 12) in the same IDLE cycle -> CAPTURE first, rd_ack 2 cycles after, rd_data[31:16]=snap_count after the increment; read addrs 13 and 15 -> rd_err=1, rd_data=0.
REQ-035 Wrap: force 65536 snapshots -> snap_count=0x0000.
REQ-036 Change detect (macro on): toggle debug_vector bit 200 -> change_flags=4'b0010. Pulse clear_change on the same cycle as a new toggle of bit 10 -> change_flags=4'b1000. With the macro off, the same stimulus -> 4'b0000.

Source files
------------

// File: rtl/nf_debug_vector_reader.sv
// nf_debug_vector_reader
//
// Snapshots a 384-bit quasi-static platform status vector (4 ports x 96 bits)
// and serves it as twelve 32-bit words through a req/ack read port. Word 12
// holds the live snapshot counter and per-port change flags; words 13..15
// return an error.
//
// Ports:
//   axi_aclk      in   1    clock, the only clock domain
//   axi_resetn    in   1    asynchronous active-low reset
//   debug_vector  in   384  port1 [383:288], port2 [287:192], port3 [191:96], port4 [95:0]
//   snap_req      in   1    single-cycle snapshot request
//   rd_req        in   1    read request, held until rd_ack
//   rd_addr       in   4    word index, stable while rd_req is high
//   rd_ack        out  1    one-cycle read completion pulse
//   rd_data       out  32   read data, zero outside rd_ack
//   rd_err        out  1    invalid address, valid with rd_ack
//   snap_count    out  16   wrapping snapshot counter
//   change_flags  out  4    sticky per-port change flags (bit0 = port1)
//   clear_change  in   1    single-cycle clear of change_flags
//
// Build option: NF_DEBUG_VECTOR_CHANGE_DETECT_EN adds a third input stage and
// per-port change detection. Without it change_flags reads 0 and clear_change
// has no effect.

module nf_debug_vector_reader (
    input  logic         axi_aclk,
    input  logic         axi_resetn,
    input  logic [383:0] debug_vector,
    input  logic         snap_req,
    input  logic         rd_req,
    input  logic [3:0]   rd_addr,
    output logic         rd_ack,
    output logic [31:0]  rd_data,
    output logic         rd_err,
    output logic [15:0]  snap_count,
    output logic [3:0]   change_flags,
    input  logic         clear_change
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [383:0]   s1_r;
    logic [383:0]   s2_r;
    logic [383:0]   snap_r;
    logic [15:0]    snap_count_r;
    logic           rd_ack_r;
    logic [31:0]    rd_data_r;
    logic           rd_err_r;
    logic           accept_s;
    logic           capture_s;
    logic [31:0]    word_s;
    logic           err_s;
    logic [3:0]     flags_s;

    // Next-state logic; a snapshot request wins over a read, which stays pending.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (snap_req) begin
                    state_s = ST_CAPTURE;
                end else if (rd_req) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: state_s = ST_IDLE;
            ST_RESP:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    assign accept_s  = (state_r == ST_IDLE) && !snap_req && rd_req;
    assign capture_s = (state_r == ST_CAPTURE);

    // Read word select from the snapshot, status word or error.
    always_comb begin
        word_s = 32'h0000_0000;
        err_s  = 1'b0;
        case (rd_addr)
            4'd0:    word_s = snap_r[383:352];
            4'd1:    word_s = snap_r[351:320];
            4'd2:    word_s = snap_r[319:288];
            4'd3:    word_s = snap_r[287:256];
            4'd4:    word_s = snap_r[255:224];
            4'd5:    word_s = snap_r[223:192];
            4'd6:    word_s = snap_r[191:160];
            4'd7:    word_s = snap_r[159:128];
            4'd8:    word_s = snap_r[127:96];
            4'd9:    word_s = snap_r[95:64];
            4'd10:   word_s = snap_r[63:32];
            4'd11:   word_s = snap_r[31:0];
            4'd12:   word_s = {snap_count_r, 12'h000, flags_s};
            default: err_s  = 1'b1;
        endcase
    end

    // Two-stage input register and FSM state.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            s1_r    <= 384'd0;
            s2_r    <= 384'd0;
            state_r <= ST_IDLE;
        end else begin
            s1_r    <= debug_vector;
            s2_r    <= s1_r;
            state_r <= state_s;
        end
    end

    // Snapshot and counter only move in CAPTURE, keeping the 12 words coherent.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            snap_r       <= 384'd0;
            snap_count_r <= 16'h0000;
        end else if (capture_s) begin
            snap_r       <= s2_r;
            snap_count_r <= snap_count_r + 16'd1;
        end else begin
            snap_r       <= snap_r;
            snap_count_r <= snap_count_r;
        end
    end

    // Response registers: loaded on the accept edge, cleared on the next edge.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_ack_r  <= 1'b0;
            rd_data_r <= 32'h0000_0000;
            rd_err_r  <= 1'b0;
        end else if (accept_s) begin
            rd_ack_r  <= 1'b1;
            rd_data_r <= word_s;
            rd_err_r  <= err_s;
        end else begin
            rd_ack_r  <= 1'b0;
            rd_data_r <= 32'h0000_0000;
            rd_err_r  <= 1'b0;
        end
    end

`ifdef NF_DEBUG_VECTOR_CHANGE_DETECT_EN
    logic [383:0] s3_r;
    logic [3:0]   diff_s;
    logic [3:0]   flags_r;

    // Per-port difference between consecutive synchronised samples.
    always_comb begin
        diff_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            diff_s[i] = (s2_r[288-96*i +: 96] != s3_r[288-96*i +: 96]);
        end
    end

    // Third stage and sticky flags; a new set beats a simultaneous clear.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            s3_r    <= 384'd0;
            flags_r <= 4'b0000;
        end else begin
            s3_r    <= s2_r;
            flags_r <= (flags_r & ~{4{clear_change}}) | diff_s;
        end
    end

    assign flags_s = flags_r;
`else
    logic unused_clear_change;
    assign unused_clear_change = clear_change;
    assign flags_s = 4'b0000;
`endif

    assign rd_ack       = rd_ack_r;
    assign rd_data      = rd_data_r;
    assign rd_err       = rd_err_r;
    assign snap_count   = snap_count_r;
    assign change_flags = flags_s;

endmodule

// File: tb/tb_nf_debug_vector_reader.sv
// Directed, table-driven bench for nf_debug_vector_reader.
module tb_nf_debug_vector_reader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [383:0] debug_vector = '0;
    logic         snap_req = 1'b0;
    logic         rd_req = 1'b0;
    logic [3:0]   rd_addr = 4'd0;
    logic         rd_ack;
    logic [31:0]  rd_data;
    logic         rd_err;
    logic [15:0]  snap_count;
    logic [3:0]   change_flags;
    logic         clear_change = 1'b0;

    int checks = 0;
    int errors = 0;
    int ack_pulses = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[16];

`ifdef NF_DEBUG_VECTOR_CHANGE_DETECT_EN
    localparam logic [3:0] FLAGS_ALL  = 4'b1111;
    localparam logic [3:0] FLAGS_P2   = 4'b0010;
    localparam logic [3:0] FLAGS_P4   = 4'b1000;
`else
    localparam logic [3:0] FLAGS_ALL  = 4'b0000;
    localparam logic [3:0] FLAGS_P2   = 4'b0000;
    localparam logic [3:0] FLAGS_P4   = 4'b0000;
`endif

    nf_debug_vector_reader dut (
        .axi_aclk     (clk),
        .axi_resetn   (rst_n),
        .debug_vector (debug_vector),
        .snap_req     (snap_req),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data),
        .rd_err       (rd_err),
        .snap_count   (snap_count),
        .change_flags (change_flags),
        .clear_change (clear_change)
    );

    always #5 clk = ~clk;

    always @(posedge rd_ack) ack_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic e, output int lat);
        rd_addr = a;
        rd_req  = 1'b1;
        lat     = 0;
        do begin
            tick();
            lat++;
        end while (rd_ack !== 1'b1 && lat < 8);
        d      = rd_data;
        e      = rd_err;
        rd_req = 1'b0;
    endtask

    task automatic snap_pulse();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        tick();
    endtask

    task automatic clear_pulse();
        clear_change = 1'b1;
        tick();
        clear_change = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          pulses_before;

        for (int k = 0; k < 12; k++) begin
            vecs[k].addr = k[3:0];
            vecs[k].data = 32'hA500_0000 + k;
            vecs[k].err  = 1'b0;
        end
        vecs[12] = '{4'd12, {16'd1, 12'h000, 4'b0000}, 1'b0};
        vecs[13] = '{4'd13, 32'h0000_0000, 1'b1};
        vecs[14] = '{4'd14, 32'h0000_0000, 1'b1};
        vecs[15] = '{4'd15, 32'h0000_0000, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_ack", {31'd0, rd_ack}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_err", {31'd0, rd_err}, 32'd0);
        chk("rst_count", {16'd0, snap_count}, 32'd0);
        chk("rst_flags", {28'd0, change_flags}, 32'd0);
        rst_n = 1'b1;

        // Reset while a read is pending behind a capture: no rd_ack, capture lost
        pulses_before = ack_pulses;
        snap_req = 1'b1;
        rd_addr  = 4'd12;
        rd_req   = 1'b1;
        tick();
        snap_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, rd_ack}, 32'd0);
        chk("midrst_count", {16'd0, snap_count}, 32'd0);
        tick();
        rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_pulses", ack_pulses, pulses_before);
        do_read(4'd12, d, e, lat);
        chk("postrst_data", d, 32'h0000_0000);
        chk("postrst_err", {31'd0, e}, 32'd0);
        chk("postrst_lat", lat, 1);
        tick();

        // Snapshot before the first capture reads zero
        do_read(4'd0, d, e, lat);
        chk("presnap_w0", d, 32'h0000_0000);
        tick();

        // Readout table
        for (int k = 0; k < 12; k++) debug_vector[32*(11-k) +: 32] = 32'hA500_0000 + k;
        repeat (5) tick();
        clear_pulse();
        snap_pulse();
        repeat (3) tick();
        chk("count_after_snap", {16'd0, snap_count}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            do_read(vecs[i].addr, d, e, lat);
            chk($sformatf("rd%0d_data", i), d, vecs[i].data);
            chk($sformatf("rd%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            chk($sformatf("rd%0d_lat", i), lat, 1);
            tick();
            chk($sformatf("rd%0d_ackdrop", i), {31'd0, rd_ack}, 32'd0);
            chk($sformatf("rd%0d_dataidle", i), rd_data, 32'd0);
        end

        // Coherence: live vector changes do not reach the snapshot
        debug_vector = {384{1'b1}};
        repeat (4) tick();
        do_read(4'd0, d, e, lat);
        chk("coh_w0", d, 32'hA500_0000);
        tick();
        do_read(4'd11, d, e, lat);
        chk("coh_w11", d, 32'hA500_000B);
        tick();
        chk("flags_all", {28'd0, change_flags}, {28'd0, FLAGS_ALL});
        clear_pulse();
        chk("flags_cleared", {28'd0, change_flags}, 32'd0);

        // snap_req during RESP is dropped
        rd_addr = 4'd3;
        rd_req  = 1'b1;
        tick();
        rd_req   = 1'b0;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        repeat (2) tick();
        chk("snap_in_resp", {16'd0, snap_count}, 32'd1);

        // snap_req held into CAPTURE counts once
        snap_req = 1'b1;
        tick();
        tick();
        snap_req = 1'b0;
        repeat (2) tick();
        chk("snap_in_capture", {16'd0, snap_count}, 32'd2);

        // Snapshot beats a simultaneous read; read sees the incremented count
        snap_req = 1'b1;
        rd_addr  = 4'd12;
        rd_req   = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("prio_ack_c1", {31'd0, rd_ack}, 32'd0);
        tick();
        chk("prio_ack_c2", {31'd0, rd_ack}, 32'd0);
        tick();
        chk("prio_ack_c3", {31'd0, rd_ack}, 32'd1);
        chk("prio_data", rd_data, {16'd3, 12'h000, 4'b0000});
        chk("prio_err", {31'd0, rd_err}, 32'd0);
        rd_req = 1'b0;
        tick();
        do_read(4'd13, d, e, lat);
        chk("a13_data", d, 32'd0);
        chk("a13_err", {31'd0, e}, 32'd1);
        tick();
        do_read(4'd15, d, e, lat);
        chk("a15_data", d, 32'd0);
        chk("a15_err", {31'd0, e}, 32'd1);
        tick();

        // Counter wrap, preloaded near the top instead of 65536 captures
        force dut.snap_count_r = 16'hFFFD;
        tick();
        release dut.snap_count_r;
        tick();
        chk("wrap_preload", {16'd0, snap_count}, 32'h0000_FFFD);
        snap_pulse();
        snap_pulse();
        chk("wrap_ffff", {16'd0, snap_count}, 32'h0000_FFFF);
        snap_pulse();
        chk("wrap_zero", {16'd0, snap_count}, 32'h0000_0000);
        do_read(4'd12, d, e, lat);
        chk("wrap_word12", d, 32'h0000_0000);
        tick();

        // Change detection: bit 200 is port2, bit 10 is port4
        debug_vector[200] = ~debug_vector[200];
        repeat (4) tick();
        chk("chg_p2", {28'd0, change_flags}, {28'd0, FLAGS_P2});
        debug_vector[10] = ~debug_vector[10];
        tick();
        tick();
        clear_change = 1'b1;
        tick();
        clear_change = 1'b0;
        chk("chg_set_wins", {28'd0, change_flags}, {28'd0, FLAGS_P4});
        repeat (2) tick();
        chk("chg_sticky", {28'd0, change_flags}, {28'd0, FLAGS_P4});
        clear_pulse();
        chk("chg_clear", {28'd0, change_flags}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
